bcd_serial_adder: RTL and testbench
===================================

// Module: bcd_serial_adder
// PURPOSE
//  Digit-serial multi-digit BCD adder, companion to the combinational BCD subtractor datapath.
//  Adds two packed-BCD operands one decimal digit per clock, LS digit first, using a start/done handshake.
//  Sits between operand registers (switch/keypad capture) and the 7-segment display driver.
// PARAMETERS
//  NDIG   4   number of BCD digits per operand (>=1); operand width = 4*NDIG
// PORTS
//  clk    in   1        system clock, rising edge
//  rst    in   1        asynchronous, active-high reset
//  start  in   1        request; sampled only in IDLE
//  a      in   4*NDIG   packed BCD operand A, digit 0 = a[3:0]
//  b      in   4*NDIG   packed BCD operand B
//  cin    in   1        decimal carry-in to digit 0
//  sum    out  4*NDIG   packed BCD result, registered
//  cout   out  1        decimal carry-out of MS digit, registered
//  busy   out  1        high while digits are being processed (RUN)
//  done   out  1        one-cycle pulse: sum/cout/err valid
//  err    out  1        an operand digit > 9 was seen in this operation
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high.
//  - Reset (any time, including mid-RUN): state=IDLE; sum=0, cout=0, busy=0, done=0, err=0; index and carry cleared.
//  - FSM: IDLE -> RUN on start=1 | RUN -> RUN while idx<NDIG-1 | RUN -> DONE after digit NDIG-1 | DONE -> IDLE unconditionally.
//  - Accept edge (IDLE & start): latch a, b into internal regs; carry<=cin; idx<=0; sum<=0; cout<=0; err<=0.
//  - RUN, per cycle, digit i=idx: t = a_i + b_i + carry (5-bit binary).
//    If t>9: digit = (t+6)[3:0], carry'=1; else digit = t[3:0], carry'=0.
//    sum[4i+:4]<=digit; carry<=carry'; idx<=idx+1; err<=err | (a_i>9) | (b_i>9).
//  - Entering DONE: cout<=final carry. In DONE: done=1 for exactly one cycle, busy=0.
//  - Latency: start sampled at edge E0 -> done high in the cycle after edge E0+NDIG (NDIG RUN cycles + 1 DONE cycle).
//  - busy=1 exactly in RUN; done=1 exactly in DONE; never both.
//  - start while in RUN or DONE is ignored (no queueing). a/b/cin may change after acceptance without effect.
//  - sum, cout, err hold their values in IDLE until the next accepted start; sum shows partial digits during RUN.
//  - Invalid digits are not saturated: the correction rule above is applied as-is, and err flags the operation.
//  - idx width = clog2(NDIG), minimum 1 bit; no wrap past NDIG-1.
// STRUCTURE
//  - Shared header bcd_defs.vh (acts as shared package): state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
//    BCD_MAX=4'd9; BCD_CORR=4'd6.
//  - Sub-module bcd_digit_add (combinational): inputs a_d[3:0], b_d[3:0], c_in; outputs d[3:0], c_out, bad.
//    Reusable by the subtractor path. Top holds the FSM, index counter, operand/sum shift-free regs and carry flop.
// TESTING (NDIG=4, values in hex = BCD)
//  1. a=0000 b=0000 cin=0, start 1 cycle -> busy 4 cycles, done at cycle 5; sum=0000 cout=0 err=0
//  2. a=9999 b=0001 cin=0 -> sum=0000 cout=1 err=0 (carry ripples through all digits)
//  3. a=1234 b=5678 cin=0 -> sum=6912 cout=0; a=0905 b=0096 cin=1 -> sum=1002 cout=0
//  4. Start held high through RUN with new operands -> result is for the first operands only;
//     next operation is accepted only after done and the return to IDLE.
//  5. Assert rst during 2nd RUN cycle -> all outputs 0 immediately (async), FSM IDLE; a fresh start then completes normally.
//  6. a=00A0 b=0001 -> err=1 at done, sum=0101 cout=0; next valid operation clears err.

Source files
------------

// File: rtl/bcd_serial_adder_pkg.sv
// Shared definitions for the digit-serial BCD adder and its digit slice.
// The subtractor datapath reuses the same constants and the same slice.
package bcd_serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

    function automatic logic is_bcd(input logic [3:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_serial_adder_if.sv
// Operand/result bundle for bcd_serial_adder; the master side requests, the slave side computes.
interface bcd_serial_adder_if #(
    parameter int NDIG = 4
);
    logic                start;
    logic [4*NDIG-1:0]   a;
    logic [4*NDIG-1:0]   b;
    logic                cin;
    logic [4*NDIG-1:0]   sum;
    logic                cout;
    logic                busy;
    logic                done;
    logic                err;

    modport master (output start, a, b, cin, input sum, cout, busy, done, err);
    modport slave  (input start, a, b, cin, output sum, cout, busy, done, err);
endinterface

// File: rtl/bcd_serial_adder_digit_add.sv
// One decimal digit of BCD addition with carry; also flags non-BCD operand digits.
// Invalid digits are corrected with the same rule, not saturated.
module bcd_digit_add
    import bcd_serial_adder_pkg::*;
(
    input  logic [3:0] a_d,
    input  logic [3:0] b_d,
    input  logic       c_in,
    output logic [3:0] d,
    output logic       c_out,
    output logic       bad
);
    logic [4:0] t;
    logic [4:0] t_corr;

    assign t      = {1'b0, a_d} + {1'b0, b_d} + {4'b0, c_in};
    assign t_corr = t + {1'b0, BCD_CORR};

    always_comb begin
        d     = t[3:0];
        c_out = 1'b0;
        if (t > {1'b0, BCD_MAX}) begin
            d     = t_corr[3:0];
            c_out = 1'b1;
        end
    end

    assign bad = !is_bcd(a_d) || !is_bcd(b_d);
endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: one digit per clock, LS digit first, start/done handshake.
// Operands are captured on acceptance so the requester may change them freely afterwards.
module bcd_serial_adder
    import bcd_serial_adder_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic              clk,
    input  logic              rst,
    bcd_serial_adder_if.slave bus
);
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

    state_t                   state_reg;
    logic [NDIG-1:0][3:0]     a_reg;
    logic [NDIG-1:0][3:0]     b_reg;
    logic [NDIG-1:0][3:0]     sum_reg;
    logic [IW-1:0]            idx_reg;
    logic                     carry_reg;
    logic                     cout_reg;
    logic                     busy_reg;
    logic                     done_reg;
    logic                     err_reg;

    logic [3:0]               dig_next;
    logic                     carry_next;
    logic                     bad_next;

    bcd_digit_add u_digit (
        .a_d   (a_reg[idx_reg]),
        .b_d   (b_reg[idx_reg]),
        .c_in  (carry_reg),
        .d     (dig_next),
        .c_out (carry_next),
        .bad   (bad_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        a_reg     <= bus.a;
                        b_reg     <= bus.b;
                        carry_reg <= bus.cin;
                        idx_reg   <= '0;
                        sum_reg   <= '0;
                        cout_reg  <= 1'b0;
                        err_reg   <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_reg[idx_reg] <= dig_next;
                    carry_reg        <= carry_next;
                    err_reg          <= err_reg | bad_next;
                    // Index parks on the last digit rather than wrapping.
                    if (idx_reg == LAST_IDX) begin
                        cout_reg  <= carry_next;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                S_DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.sum  = sum_reg;
    assign bus.cout = cout_reg;
    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.err  = err_reg;
endmodule

// File: tb/tb_bcd_serial_adder.sv
// Bench for bcd_serial_adder (NDIG=4): directed cases plus random operands against a decimal reference model.
module tb_bcd_serial_adder;
    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;

    bcd_serial_adder_if #(.NDIG(NDIG)) bus ();

    bcd_serial_adder #(.NDIG(NDIG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference: plain decimal arithmetic for valid operands; per-digit rule when a digit is not BCD.
    task automatic ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                             output logic [W-1:0] s, output logic co, output logic e);
        longint av, bv, tot, p;
        int     da, db, t, cy;
        e = 1'b0;
        s = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) e = 1'b1;
        end
        if (!e) begin
            av = 0; bv = 0; p = 1;
            for (int i = 0; i < NDIG; i++) begin
                av += longint'(a[4*i +: 4]) * p;
                bv += longint'(b[4*i +: 4]) * p;
                p  *= 10;
            end
            tot = av + bv + longint'(c);
            co  = (tot >= p);
            tot = tot % p;
            for (int i = 0; i < NDIG; i++) begin
                s[4*i +: 4] = 4'(tot % 10);
                tot = tot / 10;
            end
        end else begin
            cy = int'(c);
            for (int i = 0; i < NDIG; i++) begin
                da = int'(a[4*i +: 4]);
                db = int'(b[4*i +: 4]);
                t  = da + db + cy;
                if (t > 9) begin
                    s[4*i +: 4] = 4'((t + 6) % 16);
                    cy = 1;
                end else begin
                    s[4*i +: 4] = 4'(t);
                    cy = 0;
                end
            end
            co = cy[0];
        end
    endtask

    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        bus.a     = a;
        bus.b     = b;
        bus.cin   = c;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Entered 1 time unit after the accepting edge; ends in IDLE one cycle after done.
    task automatic complete_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W-1:0] es;
        logic         ec, ee;
        ref_model(a, b, c, es, ec, ee);
        for (int k = 0; k < NDIG; k++) begin
            check({tag, " busy_run"}, 32'(bus.busy), 32'd1);
            check({tag, " done_run"}, 32'(bus.done), 32'd0);
            @(posedge clk);
            #1;
        end
        check({tag, " done"}, 32'(bus.done), 32'd1);
        check({tag, " busy_done"}, 32'(bus.busy), 32'd0);
        check({tag, " sum"}, 32'(bus.sum), 32'(es));
        check({tag, " cout"}, 32'(bus.cout), 32'(ec));
        check({tag, " err"}, 32'(bus.err), 32'(ee));
        @(posedge clk);
        #1;
        check({tag, " done_idle"}, 32'(bus.done), 32'd0);
        check({tag, " sum_hold"}, 32'(bus.sum), 32'(es));
        $display("op %s a=%h b=%h cin=%0d -> sum=%h cout=%0d err=%0d (model %h %0d %0d)",
                 tag, a, b, c, bus.sum, bus.cout, bus.err, es, ec, ee);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        drive_start(a, b, c);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.cin   = 1'($urandom);
        complete_op(tag, a, b, c);
    endtask

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] v;
        for (int i = 0; i < NDIG; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    initial begin
        logic [W-1:0] ra, rb, ra2, rb2;
        logic         rc, rc2;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;

        #1;
        check("reset sum", 32'(bus.sum), 32'd0);
        check("reset flags", {28'd0, bus.cout, bus.busy, bus.done, bus.err}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        run_op("zero", 16'h0000, 16'h0000, 1'b0);
        run_op("ripple", 16'h9999, 16'h0001, 1'b0);
        run_op("mix1", 16'h1234, 16'h5678, 1'b0);
        run_op("mix2", 16'h0905, 16'h0096, 1'b1);
        run_op("cinmax", 16'h9999, 16'h9999, 1'b1);

        // Start held through RUN with changed operands: only the first set counts.
        ra2 = 16'h4321; rb2 = 16'h8765; rc2 = 1'b1;
        drive_start(16'h1111, 16'h2222, 1'b0);
        bus.a = ra2; bus.b = rb2; bus.cin = rc2;
        complete_op("hold1", 16'h1111, 16'h2222, 1'b0);
        check("hold idle_busy", 32'(bus.busy), 32'd0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        complete_op("hold2", ra2, rb2, rc2);

        // Asynchronous reset during the second RUN cycle.
        drive_start(16'h5555, 16'h5555, 1'b1);
        bus.start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid sum", 32'(bus.sum), 32'd0);
        check("rst_mid flags", {28'd0, bus.cout, bus.busy, bus.done, bus.err}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid stays_idle", 32'(bus.busy), 32'd0);
        run_op("after_rst", 16'h0042, 16'h0058, 1'b0);

        run_op("invalid", 16'h00A0, 16'h0001, 1'b0);
        run_op("err_clear", 16'h0001, 16'h0002, 1'b0);
        run_op("invalid_b", 16'h0000, 16'hF00F, 1'b1);

        for (int n = 0; n < 16; n++) begin
            ra = rand_bcd();
            rb = rand_bcd();
            rc = 1'($urandom);
            run_op("rand_bcd", ra, rb, rc);
        end
        for (int n = 0; n < 6; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            run_op("rand_any", ra, rb, rc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
